// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu -- sequential ALU with a valid/ready request and result handshake.
//
// A request is accepted in IDLE (in_valid && in_ready). The operands and opcode
// are latched, so later input changes cannot affect that operation. The next
// cycle (EXEC) either finishes a single-cycle operation or loads the iterative
// datapath. The result and flags then hold in DONE until out_valid && out_ready.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    request valid
//   in_ready    block can accept a request (IDLE only)
//   A, B        operands, WIDTH bits
//   opcode      operation select (4 bits)
//   out_valid   result/flags valid (DONE only)
//   out_ready   consumer accepts the result
//   result      operation result, WIDTH bits
//   carry_flag  carry / borrow / multiply overflow / divide-by-zero
//   zero_flag   result == 0
//
// Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOT A, 0101 MUL,
//          0110 DIV, 0111 XOR, 1111 PASS A. Any other code gives 0 with no carry.
//
// Build option: macro SEQ_ALU_MULDIV_EN.
//   Defined:   MUL is shift-add over WIDTH cycles and DIV is restoring division
//              over WIDTH cycles. DIV by zero finishes in one cycle with all
//              ones and carry set.
//   Undefined: MUL and DIV are treated as undefined opcodes, with one-cycle
//              latency. The BUSY state, the counter and the shift registers
//              are not built.
// -----------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_flag,
  output logic             zero_flag
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_PASS = 4'b1111;

`ifdef SEQ_ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  // Single-cycle datapath, evaluated from the latched operands.
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  always_comb begin
    add_w     = {1'b0, a_q} + {1'b0, b_q};
    // The top bit of the zero-extended difference is the borrow, so it is 1 exactly when A < B.
    sub_w     = {1'b0, a_q} - {1'b0, b_q};
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (op_q)
      OP_ADD:  begin alu_res = add_w[WIDTH-1:0]; alu_carry = add_w[WIDTH]; end
      OP_SUB:  begin alu_res = sub_w[WIDTH-1:0]; alu_carry = sub_w[WIDTH]; end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_NOT:  alu_res = ~a_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_PASS: alu_res = a_q;
`ifdef SEQ_ALU_MULDIV_EN
      // Only the B == 0 case reaches this path. Nonzero divisors go to BUSY.
      OP_DIV:  begin alu_res = '1; alu_carry = 1'b1; end
`endif
      default: ;  // undefined opcodes (and MUL/DIV when the option is off) give 0
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // hi/lo hold the product halves during MUL.
  // During DIV they hold the remainder and the dividend/quotient.
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             iter_op;
  logic             last_step;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff, div_rem_nx, div_quo_nx;
  logic             div_ge;

  always_comb begin
    iter_op   = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
    last_step = (cnt_q == CW'(WIDTH - 1));

    // Shift-add step: add the multiplicand when the multiplier LSB is set,
    // then shift {carry, hi, lo} right by one.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_hi_nx = mul_sum[WIDTH:1];
    mul_lo_nx = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring step: shift the next dividend bit into the remainder, then
    // subtract the divisor if it fits. The remainder stays below B, so the
    // difference fits in WIDTH bits.
    div_shift  = {hi_q, lo_q[WIDTH-1]};
    div_ge     = (div_shift >= {1'b0, b_q});
    div_diff   = div_shift[WIDTH-1:0] - b_q;
    div_rem_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_quo_nx = {lo_q[WIDTH-2:0], div_ge};
  end
`endif

  // NOTE: every *_d gets a default first, so no path through the case leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
`ifdef SEQ_ALU_MULDIV_EN
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          op_d    = opcode;
          state_d = EXEC;
        end
      end

      EXEC: begin
`ifdef SEQ_ALU_MULDIV_EN
        if (iter_op) begin
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = (op_q == OP_MUL) ? b_q : a_q;
          state_d = BUSY;
        end else begin
`else
        begin
`endif
          result_d = alu_res;
          carry_d  = alu_carry;
          zero_d   = (alu_res == '0);
          state_d  = DONE;
        end
      end

`ifdef SEQ_ALU_MULDIV_EN
      BUSY: begin
        hi_d = (op_q == OP_MUL) ? mul_hi_nx : div_rem_nx;
        lo_d = (op_q == OP_MUL) ? mul_lo_nx : div_quo_nx;
        if (last_step) begin
          state_d = DONE;
          if (op_q == OP_MUL) begin
            result_d = mul_lo_nx;
            carry_d  = (mul_hi_nx != '0);
            zero_d   = (mul_lo_nx == '0);
          end else begin
            result_d = div_quo_nx;
            carry_d  = 1'b0;
            zero_d   = (div_quo_nx == '0);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge, whatever order the
  // statements are written in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  // NOTE: the operand and iteration registers have no reset. They are always
  // loaded before they are read, and leaving them out of reset keeps reset
  // off the wide datapath.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
`ifdef SEQ_ALU_MULDIV_EN
    cnt_q <= cnt_d;
    hi_q  <= hi_d;
    lo_q  <= lo_d;
`endif
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign result     = result_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have one parameter: WIDTH, 8, operand/result width in bits (legal 2..32).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1, operation request valid.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 The block SHALL have ports A and B, input, WIDTH, operands.
REQ-008 The block SHALL have port opcode, input, 4, operation select.
REQ-009 The block SHALL have port out_valid, output, 1, result/flags valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 The block SHALL have port result, output, WIDTH, operation result.
REQ-012 The block SHALL have ports carry_flag and zero_flag, output, 1 each, carry/borrow/overflow and result==0.

Function
REQ-013 The block SHALL accept a request on a rising edge where in_valid && in_ready, latching A, B and opcode; later input changes SHALL NOT affect that operation.
REQ-014 The block SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 NOT A, 0101 MUL, 0110 DIV, 0111 XOR, 1111 PASS A; all others undefined.
REQ-016 ADD SHALL give result = (A+B) mod 2^WIDTH, carry_flag = carry out of bit WIDTH-1.
REQ-017 SUB SHALL give result = (A-B) mod 2^WIDTH, carry_flag = 1 iff A < B (borrow).
REQ-018 Logic ops and PASS A SHALL set carry_flag = 0.
REQ-019 MUL SHALL be iterative shift-add over WIDTH cycles; result = low WIDTH bits of A*B; carry_flag = 1 iff the high WIDTH bits are nonzero.
REQ-020 DIV SHALL be iterative restoring division over WIDTH cycles; result = floor(A/B), carry_flag = 0.
REQ-021 DIV with B = 0 SHALL skip BUSY and give result = all ones, carry_flag = 1.
REQ-022 Undefined opcodes SHALL give result = 0, carry_flag = 0.
REQ-023 zero_flag SHALL equal (result == 0) for every operation, including MUL overflow.
REQ-024 Latency: accept at edge N; single-cycle ops, DIV-by-zero and undefined ops SHALL raise out_valid after edge N+1; MUL/DIV after edge N+1+WIDTH.
REQ-025 In DONE, result and flags SHALL hold stable until out_valid && out_ready; that edge returns the FSM to IDLE.
REQ-026 The block SHALL NOT accept a new request in the cycle a result is consumed; in_ready rises the following cycle.
REQ-027 An iteration counter SHALL count WIDTH steps exactly; no wrap or early exit except REQ-021.

Reset
REQ-028 With rst = 1 at a rising edge the FSM SHALL enter IDLE and set result = 0, carry_flag = 0, zero_flag = 0, out_valid = 0, in_ready = 1 after that edge.
REQ-029 Reset during BUSY or DONE SHALL abort the operation with no result delivered; rst has priority over in_valid and out_ready.

Configuration
REQ-030 Macro SEQ_ALU_MULDIV_EN SHALL gate the iterative datapath: defined -> MUL/DIV per REQ-019..021; undefined -> opcodes 0101/0110 are undefined per REQ-022 with 1-cycle latency, and the BUSY state, counter and multiply/divide registers are not synthesised.

Verification (WIDTH = 8, macro defined unless stated)
REQ-031 ADD A=200, B=100 -> result 44, carry 1, zero 0, out_valid 1 cycle after accept.
REQ-032 SUB A=5, B=5 -> result 0, zero 1, carry 0; SUB A=3, B=4 -> result 255, carry 1.
REQ-033 MUL A=15, B=17 -> result 255, carry 0 after 9 cycles; MUL A=16, B=16 -> result 0, carry 1, zero 1.
REQ-034 DIV A=9, B=3 -> result 3, carry 0 after 9 cycles; DIV A=5, B=0 -> result 255, carry 1 after 1 cycle.
REQ-035 Hold out_ready = 0 for 3 cycles in DONE -> result/flags stable, in_ready 0; new in_valid ignored until consumed.
REQ-036 Assert rst 4 cycles into a MUL -> next cycle IDLE, out_valid 0, result 0; macro undefined: MUL A=3, B=4 -> result 0, zero 1, 1-cycle latency.
